// File: rtl/sparse_token_if.sv
// Controller-facing bundle for the neuron-core sequencer: scheduler, CSRAM, neuron block and router.
// The master side is the controller. The slave side is the surrounding core.
interface sparse_token_if #(
    parameter int NUM_AXONS   = 256,
    parameter int NUM_NEURONS = 256,
    parameter int NUM_WEIGHTS = 4
);
    localparam int AW = $clog2(NUM_AXONS);
    localparam int NW = $clog2(NUM_NEURONS);
    localparam int IW = $clog2(NUM_WEIGHTS);

    logic                 tick_i;
    logic                 core_active_i;
    logic [NW:0]          cfg_num_neurons_i;
    logic [NUM_AXONS-1:0] axon_spikes_i;
    logic [NUM_AXONS-1:0] synapses_i;
    logic                 tc_modify_model_i;
    logic [AW-1:0]        tc_addr_i;
    logic [IW-1:0]        tc_data_i;
    logic                 spike_in_i;
    logic                 spike_ready_i;

    logic                 scheduler_set_o;
    logic                 scheduler_clr_o;
    logic [NW-1:0]        csram_addr_o;
    logic                 csram_write_o;
    logic [IW-1:0]        neuron_instruction_o;
    logic                 neuron_reg_en_o;
    logic                 next_neuron_o;
    logic                 write_current_potential_o;
    logic                 spike_valid_o;
    logic                 done_o;
    logic                 error_o;

    modport master (
        input  tick_i, core_active_i, cfg_num_neurons_i, axon_spikes_i, synapses_i,
               tc_modify_model_i, tc_addr_i, tc_data_i, spike_in_i, spike_ready_i,
        output scheduler_set_o, scheduler_clr_o, csram_addr_o, csram_write_o,
               neuron_instruction_o, neuron_reg_en_o, next_neuron_o,
               write_current_potential_o, spike_valid_o, done_o, error_o
    );

    modport slave (
        output tick_i, core_active_i, cfg_num_neurons_i, axon_spikes_i, synapses_i,
               tc_modify_model_i, tc_addr_i, tc_data_i, spike_in_i, spike_ready_i,
        input  scheduler_set_o, scheduler_clr_o, csram_addr_o, csram_write_o,
               neuron_instruction_o, neuron_reg_en_o, next_neuron_o,
               write_current_potential_o, spike_valid_o, done_o, error_o
    );
endinterface

// File: rtl/sparse_token_controller.sv
// Per-tick neuron sequencer: integrates only axons that have both a spike and a synapse. It uses an LSB scan, costing max(1, popcount) integrate cycles per neuron.
// spike_valid is held until spike_ready, and the neuron's potential write-back waits for that handshake.
module sparse_token_controller #(
    parameter int NUM_AXONS   = 256,
    parameter int NUM_NEURONS = 256,
    parameter int NUM_WEIGHTS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sparse_token_if.master       bus
);
    localparam int AW = $clog2(NUM_AXONS);
    localparam int NW = $clog2(NUM_NEURONS);
    localparam int IW = $clog2(NUM_WEIGHTS);
    localparam logic [NW:0] NN_MAX = (NW+1)'(NUM_NEURONS);

    typedef enum logic [2:0] {
        S_IDLE, S_SET, S_LOAD, S_INIT, S_INTEG, S_WRITE, S_NEXT, S_CLR
    } state_t;

    state_t               state_q, state_d;
    logic [NW-1:0]        addr_q, addr_d;
    logic [NW:0]          n_q, n_d;
    logic [NUM_AXONS-1:0] pend_q, pend_d;
    logic                 sv_q, sv_d;
    logic                 wb_q, wb_d;
    logic                 err_q, err_d;

    logic [IW-1:0]        tbl_q [NUM_AXONS];

    logic [NUM_AXONS-1:0] pend_init;
    logic                 sched_set, sched_clr, cs_write, reg_en, nxt_neuron, wcp, done;
    logic [IW-1:0]        instr;

    function automatic logic [AW-1:0] lsb_idx(input logic [NUM_AXONS-1:0] v);
        lsb_idx = '0;
        for (int i = NUM_AXONS - 1; i >= 0; i--) begin
            if (v[i]) lsb_idx = AW'(i);
        end
    endfunction

    // The table deliberately has no reset, so the axon-type model survives a core reset.
    always_ff @(posedge clk) begin
        if (bus.tc_modify_model_i) tbl_q[bus.tc_addr_i] <= bus.tc_data_i;
    end

    assign pend_init = bus.axon_spikes_i & bus.synapses_i;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        n_d        = n_q;
        pend_d     = pend_q;
        sv_d       = sv_q;
        wb_d       = wb_q;
        err_d      = err_q | (bus.tick_i && (state_q != S_IDLE));
        sched_set  = 1'b0;
        sched_clr  = 1'b0;
        cs_write   = 1'b0;
        reg_en     = 1'b0;
        nxt_neuron = 1'b0;
        wcp        = 1'b0;
        done       = 1'b0;
        instr      = '0;
        case (state_q)
            S_IDLE: begin
                pend_d = '0;
                sv_d   = 1'b0;
                wb_d   = 1'b0;
                if (bus.tick_i) begin
                    addr_d  = '0;
                    n_d     = (bus.cfg_num_neurons_i == '0 || bus.cfg_num_neurons_i > NN_MAX)
                              ? NN_MAX : bus.cfg_num_neurons_i;
                    state_d = S_SET;
                end
            end
            S_SET: begin
                sched_set = 1'b1;
                state_d   = S_LOAD;
            end
            S_LOAD: state_d = S_INIT;
            S_INIT: begin
                nxt_neuron = 1'b1;
                reg_en     = 1'b1;
                if (pend_init == '0) wcp = 1'b1;
                else instr = tbl_q[lsb_idx(pend_init)];
                // v & (v-1) drops the lowest set bit.
                pend_d  = pend_init & (pend_init - 1'b1);
                state_d = S_INTEG;
            end
            S_INTEG: begin
                if (pend_q != '0) begin
                    reg_en = 1'b1;
                    instr  = tbl_q[lsb_idx(pend_q)];
                    pend_d = pend_q & (pend_q - 1'b1);
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Sub-phases: decide fire, hold valid until accepted, then one write-back cycle.
                if (sv_q) begin
                    if (bus.spike_ready_i) begin
                        sv_d = 1'b0;
                        wb_d = 1'b1;
                    end
                end else if (wb_q) begin
                    cs_write = 1'b1;
                    wb_d     = 1'b0;
                    state_d  = S_NEXT;
                end else if (bus.spike_in_i && bus.core_active_i) begin
                    sv_d = 1'b1;
                end else begin
                    cs_write = 1'b1;
                    state_d  = S_NEXT;
                end
            end
            S_NEXT: begin
                if ({1'b0, addr_q} == n_q - 1'b1) begin
                    state_d = S_CLR;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_CLR: begin
                sched_clr = 1'b1;
                done      = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            n_q     <= '0;
            pend_q  <= '0;
            sv_q    <= 1'b0;
            wb_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            n_q     <= n_d;
            pend_q  <= pend_d;
            sv_q    <= sv_d;
            wb_q    <= wb_d;
            err_q   <= err_d;
        end
    end

    assign bus.scheduler_set_o           = sched_set;
    assign bus.scheduler_clr_o           = sched_clr;
    assign bus.csram_addr_o              = addr_q;
    assign bus.csram_write_o             = cs_write;
    assign bus.neuron_instruction_o      = instr;
    assign bus.neuron_reg_en_o           = reg_en;
    assign bus.next_neuron_o             = nxt_neuron;
    assign bus.write_current_potential_o = wcp;
    assign bus.spike_valid_o             = sv_q;
    assign bus.done_o                    = done;
    assign bus.error_o                   = err_q;
endmodule
